jtframe_rom_sched: RTL
======================

Name: jtframe_rom_sched

Overview:
- Round-robin scheduler that shares the single game-side SDRAM read port (sdram_req/sdram_ack/data_rdy/data_read) between SLOTS independent ROM requesters (CPU, tiles, sprites, sound).
- Each slot keeps a one-word cache with tag. Only misses go to SDRAM.
- Sits between the game ROM clients and the frame SDRAM controller, inside the game top.
- Drives refresh_en so refresh happens only while the port is idle.

Parameters:
- SLOTS, 4: number of requesters, 2..8.
- AW, 22: SDRAM word-address width.
- DW, 32: SDRAM read data width.
- TOUT, 255: cycles allowed in WAIT_DATA before abort.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- downloading  in  1  ROM download in progress; port owned by loader
- slot_req  in  SLOTS  per-slot read request, level
- slot_addr  in  SLOTS*AW  per-slot word address; slot i at [i*AW +: AW]
- slot_ok  out  SLOTS  slot data valid for the current slot_addr
- slot_dout  out  SLOTS*DW  per-slot cached data
- sdram_req  out  1  request to SDRAM controller
- sdram_addr  out  AW  address of the granted slot
- sdram_ack  in  1  controller accepted the request (1-cycle pulse)
- data_rdy  in  1  data_read valid (1-cycle pulse)
- data_read  in  DW  SDRAM read data
- refresh_en  out  1  refresh permitted
- timeout  out  1  sticky flag: a WAIT_DATA abort occurred

Behaviour:
- Reset values: sdram_req=0, sdram_addr=0, slot_dout=0, all valid bits and tags =0, slot_ok=0, refresh_en=0, timeout=0, state=IDLE, RR pointer=0 (slot 0 highest priority).
- Hit definition: hit[i] = valid[i] && tag[i]==slot_addr[i]. Combinational.
- slot_ok[i] = slot_req[i] && hit[i]. Combinational. It drops in the same cycle slot_addr changes to a non-matching value.
- Miss definition: miss[i] = slot_req[i] && !hit[i] && !downloading.

State machine:
- IDLE
  - If any miss: grant the first missing slot at or after the RR pointer, wrapping modulo SLOTS.
  - Register gnt, sdram_addr=slot_addr[gnt], sdram_req=1, go to WAIT_ACK.
  - RR pointer becomes gnt+1 mod SLOTS.
  - refresh_en=1 only in IDLE with no miss.
- WAIT_ACK
  - Hold sdram_req and sdram_addr stable until sdram_ack.
  - On ack: sdram_req=0, clear timeout counter, go to WAIT_DATA.
- WAIT_DATA
  - On data_rdy: slot_dout[gnt]=data_read, tag[gnt]=sdram_addr (grant-time address), valid[gnt]=1, go to IDLE.
  - If the counter reaches TOUT: set timeout, leave valid unchanged, go to IDLE.

Latency:
- Miss visible in cycle N (state IDLE) -> sdram_req=1 in N+1.
- data_rdy in cycle M -> slot_ok=1 in M+1 if slot_addr is unchanged.
- A cache hit gives slot_ok in the same cycle.

Boundary cases:
- slot_addr changes while its fetch is in flight: data is stored under the old tag and slot_ok stays 0. The slot re-misses in the next IDLE.
- sdram_ack and data_rdy in the same cycle while in WAIT_ACK: treat as ack, then complete the fill in the same cycle and go to IDLE.
- data_rdy outside WAIT_DATA (or WAIT_ACK with ack) is ignored.
- New miss in the same cycle as data_rdy: granted from IDLE on the next cycle. No back-to-back grant.
- downloading=1:
  - All valid bits clear every cycle and sdram_req=0.
  - State forced to IDLE within 1 cycle, even mid-transaction.
  - refresh_en=0.
  - After downloading falls, all slots miss.
- rst mid-transaction: everything returns to reset values next cycle. Any late data_rdy is ignored.
- slot_req deasserted after grant: the fill still completes and updates the cache.

Test Plan:
1. Single miss: slot 1 req addr 0x00100, ack 2 cycles later, data_rdy 4 cycles after ack with 0xDEADBEEF -> sdram_addr=0x00100 while req; slot_ok[1]=1 and slot_dout[1]=0xDEADBEEF one cycle after data_rdy; a second identical request hits with no sdram_req.
2. Round-robin: slots 0,2,3 all missing continuously -> grant order 0,2,3,0; after slot 3, slot 0 is granted before 2; refresh_en=0 throughout.
3. Address change in flight: slot 0 req 0x00010, change to 0x00020 after ack -> fill stored at tag 0x00010, slot_ok[0]=0, next sdram_addr=0x00020.
4. Download abort: assert downloading during WAIT_DATA -> sdram_req=0, state IDLE next cycle, all slot_ok=0 after downloading falls until refetch.
5. Timeout: ack but no data_rdy for 255 cycles -> timeout=1 sticky, return to IDLE, next miss re-requested; rst clears timeout.
6. Idle refresh: no requests for 10 cycles -> refresh_en=1; any miss drops refresh_en in the same cycle.

Source files
------------

// File: rtl/jtframe_rom_sched.sv
// Round-robin scheduler sharing one SDRAM read port between SLOTS ROM clients,
// each slot backed by a single-word tagged cache; refresh is allowed only when idle.
module jtframe_rom_sched #(
    parameter int SLOTS = 4,
    parameter int AW    = 22,
    parameter int DW    = 32,
    parameter int TOUT  = 255
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                downloading,
    input  logic [SLOTS-1:0]    slot_req,
    input  logic [SLOTS*AW-1:0] slot_addr,
    output logic [SLOTS-1:0]    slot_ok,
    output logic [SLOTS*DW-1:0] slot_dout,
    output logic                sdram_req,
    output logic [AW-1:0]       sdram_addr,
    input  logic                sdram_ack,
    input  logic                data_rdy,
    input  logic [DW-1:0]       data_read,
    output logic                refresh_en,
    output logic                timeout
);
    localparam int GW = $clog2(SLOTS);
    localparam int CW = $clog2(TOUT + 1);

    typedef enum logic [1:0] {IDLE, WAIT_ACK, WAIT_DATA} state_t;

    state_t         state;
    logic [SLOTS-1:0] valid, hit, miss;
    logic [AW-1:0]  tag [SLOTS];
    logic [GW-1:0]  ptr, gnt, sel, sel_next;
    logic [CW-1:0]  cnt;
    logic           any_miss, fill;

    always_comb begin
        hit  = '0;
        miss = '0;
        for (int unsigned i = 0; i < SLOTS; i++) begin
            hit[i]  = valid[i] && (tag[i] == slot_addr[i*AW +: AW]);
            miss[i] = slot_req[i] && !hit[i] && !downloading;
        end
    end

    assign slot_ok = slot_req & hit;

    // First missing slot at or after the round-robin pointer, wrapping.
    always_comb begin
        int unsigned idx;
        idx      = 0;
        sel      = '0;
        any_miss = 1'b0;
        for (int unsigned k = 0; k < SLOTS; k++) begin
            idx = 32'(ptr) + k;
            if (idx >= SLOTS)
                idx = idx - SLOTS;
            if (!any_miss && miss[idx[GW-1:0]]) begin
                any_miss = 1'b1;
                sel      = idx[GW-1:0];
            end
        end
    end

    assign sel_next   = (32'(sel) == SLOTS - 1) ? '0 : sel + 1'b1;
    assign fill       = data_rdy && ((state == WAIT_DATA) || (state == WAIT_ACK && sdram_ack));
    assign refresh_en = !rst && !downloading && (state == IDLE) && !any_miss;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            valid      <= '0;
            for (int unsigned i = 0; i < SLOTS; i++)
                tag[i] <= '0;
            ptr        <= '0;
            gnt        <= '0;
            cnt        <= '0;
            sdram_req  <= 1'b0;
            sdram_addr <= '0;
            slot_dout  <= '0;
            timeout    <= 1'b0;
        end else if (downloading) begin
            valid     <= '0;
            sdram_req <= 1'b0;
            state     <= IDLE;
        end else begin
            // Tag with the grant-time address so a client that moved on re-misses.
            if (fill) begin
                slot_dout[gnt*DW +: DW] <= data_read;
                tag[gnt]                <= sdram_addr;
                valid[gnt]              <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (any_miss) begin
                        gnt        <= sel;
                        sdram_addr <= slot_addr[sel*AW +: AW];
                        sdram_req  <= 1'b1;
                        ptr        <= sel_next;
                        state      <= WAIT_ACK;
                    end
                end
                WAIT_ACK: begin
                    if (sdram_ack) begin
                        sdram_req <= 1'b0;
                        cnt       <= '0;
                        state     <= data_rdy ? IDLE : WAIT_DATA;
                    end
                end
                WAIT_DATA: begin
                    if (data_rdy) begin
                        state <= IDLE;
                    end else if (cnt == CW'(TOUT - 1)) begin
                        timeout <= 1'b1;
                        state   <= IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
